// File: rtl/lynx_video_pkg.sv
// Shared bitplane video definitions: plane codes, writer states, pixel addressing helpers.
// Used by the shifter, the fetch address generator and the pixel writer.
package lynx_video_pkg;

  localparam logic [1:0] PL_BLUE   = 2'd0;
  localparam logic [1:0] PL_RED    = 2'd1;
  localparam logic [1:0] PL_GREENX = 2'd2;
  localparam logic [1:0] PL_GREEN  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEEK,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_DONE
  } wr_state_t;

  // x[2:0]=0 is the leftmost pixel, which the shifter emits from bit 7.
  function automatic logic [7:0] bit_mask(input logic [2:0] xb);
    return 8'h80 >> xb;
  endfunction

  function automatic logic [14:0] pack_addr(input logic [1:0] plane, input logic [7:0] y,
                                            input logic [7:0] x);
    return {plane, y, x[7:3]};
  endfunction

endpackage

// File: rtl/lynx_rmw_merge.sv
// Combinational pixel merge: sets/clears or toggles one bit of a plane byte.
// Zero latency, no flow control.
module lynx_rmw_merge
  import lynx_video_pkg::*;
(
  input  logic [7:0] rd,
  input  logic [2:0] x_bit,
  input  logic       col_bit,
  input  logic       op,
  output logic [7:0] wdata
);

  logic [7:0] mask8;
  logic [7:0] set8;

  assign mask8 = bit_mask(x_bit);
  assign set8  = col_bit ? mask8 : 8'h00;
  assign wdata = op ? (rd ^ set8) : ((rd & ~mask8) | set8);

endmodule

// File: rtl/lynx_pixel_writer.sv
// Single-pixel plotter: read-modify-write of up to four bitplanes over a shared RAM port.
// Latency 2 + planes*(3+RD_LAT) cycles when the RAM is free; strobes stall while mem_busy.
module lynx_pixel_writer
  import lynx_video_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_x,
  input  logic [7:0]  req_y,
  input  logic [3:0]  req_col,
  input  logic [3:0]  req_mask,
  input  logic        req_op,
  output logic        done,
  input  logic        mem_busy,
  output logic [14:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam logic [2:0] LAT = 3'(RD_LAT);

  wr_state_t  state, state_nxt;
  logic [7:0] x_q, y_q;
  logic [3:0] col_q, rem_q;
  logic       op_q;
  logic [1:0] plane_q, first_plane;
  logic [7:0] rdata_q;
  logic [2:0] cnt_q;
  logic [7:0] merged;
  logic       accept;

  assign accept = req_valid & req_ready;

  always_comb begin
    first_plane = PL_GREEN;
    if (rem_q[PL_BLUE])        first_plane = PL_BLUE;
    else if (rem_q[PL_RED])    first_plane = PL_RED;
    else if (rem_q[PL_GREENX]) first_plane = PL_GREENX;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Strobes are also masked by reset so an abort issues nothing in the reset cycle.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    done      = 1'b0;
    mem_rd    = 1'b0;
    mem_we    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ST_SEEK;
      end
      ST_SEEK: state_nxt = (rem_q == 4'd0) ? ST_DONE : ST_RD;
      ST_RD: begin
        if (!mem_busy && !reset) begin
          mem_rd    = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: if (cnt_q == LAT) state_nxt = ST_WR;
      ST_WR: begin
        if (!mem_busy && !reset) begin
          mem_we    = 1'b1;
          state_nxt = ST_SEEK;
        end
      end
      ST_DONE: begin
        done      = ~reset;
        req_ready = 1'b1;
        state_nxt = req_valid ? ST_SEEK : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q      <= 8'd0;
      y_q      <= 8'd0;
      col_q    <= 4'd0;
      rem_q    <= 4'd0;
      op_q     <= 1'b0;
      plane_q  <= 2'd0;
      mem_addr <= 15'd0;
      rdata_q  <= 8'd0;
      cnt_q    <= 3'd0;
    end else begin
      if (accept) begin
        x_q   <= req_x;
        y_q   <= req_y;
        col_q <= req_col;
        rem_q <= req_mask;
        op_q  <= req_op;
      end
      if (state == ST_SEEK && rem_q != 4'd0) begin
        plane_q  <= first_plane;
        mem_addr <= pack_addr(first_plane, y_q, x_q);
      end
      if (mem_rd) cnt_q <= 3'd1;
      if (state == ST_WAIT) begin
        if (cnt_q == LAT) rdata_q <= mem_rdata;
        else              cnt_q   <= cnt_q + 3'd1;
      end
      if (mem_we) rem_q[plane_q] <= 1'b0;
    end
  end

  lynx_rmw_merge u_merge (
    .rd      (rdata_q),
    .x_bit   (x_q[2:0]),
    .col_bit (col_q[plane_q]),
    .op      (op_q),
    .wdata   (merged)
  );

  assign mem_wdata = (state == ST_WR) ? merged : 8'h00;

endmodule
